// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and forwarding control for a five-stage pipeline
// Optional FORWARD_EN macro: load-use-only stalls plus EX operand forwarding from MEM/WB.

module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_wr,
  input  logic [4:0]  id_dst,
  input  logic        id_load,
  input  logic        mem_redirect,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_bubble,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       load;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } slot_t;

  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;
  slot_t id_slot;
  logic  hazard_rs;
  logic  hazard_rt;
  logic  redirect;
  logic  stall;

  // A slot only produces a register when valid and never for $0.
  function automatic logic writes_reg(input slot_t s, input logic [4:0] r);
    return s.valid && (r != 5'd0) && (s.dst == r);
  endfunction

`ifdef FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] r,
                                         input slot_t m, input slot_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && writes_reg(w, r))
      sel = 2'b10;
    if (use_src && writes_reg(m, r) && !m.load)
      sel = 2'b01;
    return sel;
  endfunction
`endif

  always_comb begin
    id_slot        = '0;
    id_slot.valid  = id_wr && (id_dst != 5'd0);
    id_slot.dst    = id_dst;
    id_slot.load   = id_load;
    id_slot.rs     = id_rs;
    id_slot.rt     = id_rt;
    id_slot.use_rs = id_use_rs;
    id_slot.use_rt = id_use_rt;
  end

  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
`ifdef FORWARD_EN
    hazard_rs = id_use_rs && ex_q.load && writes_reg(ex_q, id_rs);
    hazard_rt = id_use_rt && ex_q.load && writes_reg(ex_q, id_rt);
`else
    hazard_rs = id_use_rs && (writes_reg(ex_q, id_rs) || writes_reg(mem_q, id_rs));
    hazard_rt = id_use_rt && (writes_reg(ex_q, id_rt) || writes_reg(mem_q, id_rt));
`endif
  end

  // Redirect wins over stall; reset forces the free-running, no-flush state.
  assign redirect = mem_redirect && !rst;
  assign stall    = (hazard_rs || hazard_rt) && !mem_redirect && !rst;

  assign pc_en        = !stall;
  assign if_id_en     = !stall;
  assign id_ex_bubble = stall;
  assign flush_if_id  = redirect;
  assign flush_id_ex  = redirect;
  assign flush_ex_mem = redirect;

`ifdef FORWARD_EN
  assign fwd_a = rst ? 2'b00 : fwd_sel(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
  assign fwd_b = rst ? 2'b00 : fwd_sel(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_q  <= (stall || redirect) ? slot_t'('0) : id_slot;
      mem_q <= redirect ? slot_t'('0) : ex_q;
      wb_q  <= mem_q;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (redirect && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  // Not every slot field is consumed in every build.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_use_rs, id_use_rt, id_wr, id_load, mem_redirect;
  logic        pc_en, if_id_en, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr(id_wr), .id_dst(id_dst), .id_load(id_load), .mem_redirect(mem_redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_bubble(id_ex_bubble),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: history of what entered EX; index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       ld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
  } ins_t;

  ins_t        hist[$];
  int unsigned m_stalls = 0;
  int unsigned m_flushes = 0;
  logic        e_pc, e_ifid, e_bub, e_fl, e_stall;
  logic [1:0]  e_fa, e_fb;

  function automatic bit writes(ins_t x, logic [4:0] r);
    return x.v && (r != 5'd0) && (x.dst == r);
  endfunction

  function automatic bit src_hazard(logic u, logic [4:0] r, ins_t ex, ins_t mem);
    if (!u) return 1'b0;
    if (FWD) return ex.ld && writes(ex, r);
    return writes(ex, r) || writes(mem, r);
  endfunction

  function automatic logic [1:0] fwd_pick(logic u, logic [4:0] r, ins_t mem, ins_t wb);
    if (!FWD || !u) return 2'b00;
    if (writes(mem, r) && !mem.ld) return 2'b01;
    if (writes(wb, r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [15:0] sat16(int unsigned n);
    return (n > 65535) ? 16'hFFFF : n[15:0];
  endfunction

  task automatic model_eval();
    e_stall = src_hazard(id_use_rs, id_rs, hist[0], hist[1]) ||
              src_hazard(id_use_rt, id_rt, hist[0], hist[1]);
    if (rst || mem_redirect) e_stall = 1'b0;
    e_pc   = !e_stall;
    e_ifid = !e_stall;
    e_bub  = e_stall;
    e_fl   = mem_redirect && !rst;
    e_fa   = rst ? 2'b00 : fwd_pick(hist[0].urs, hist[0].rs, hist[1], hist[2]);
    e_fb   = rst ? 2'b00 : fwd_pick(hist[0].urt, hist[0].rt, hist[1], hist[2]);
  endtask

  task automatic model_edge();
    ins_t nx;
    if (rst) begin
      hist.delete();
      repeat (3) hist.push_back('0);
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      nx = '{v: id_wr && (id_dst != 5'd0), dst: id_dst, ld: id_load, rs: id_rs, rt: id_rt,
             urs: id_use_rs, urt: id_use_rt};
      if (e_stall) m_stalls++;
      if (mem_redirect) begin
        m_flushes++;
        hist[0] = '0;
      end
      if (e_stall || mem_redirect) nx = '0;
      hist.push_front(nx);
      void'(hist.pop_back());
    end
  endtask

  task automatic tick();
    model_eval();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(bit wr, logic [4:0] dst, bit ld, bit urs, logic [4:0] rs, bit urt, logic [4:0] rt);
    id_wr = wr; id_dst = dst; id_load = ld;
    id_use_rs = urs; id_rs = rs; id_use_rt = urt; id_rt = rt;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_redirect = 1'b0; nop();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_redirect = 1'b1;
    set_id(1, 5, 1, 1, 5, 1, 5);
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if ({pc_en, if_id_en, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b} !== 10'b11_0000_0000) begin
        errors++;
        $display("FAIL reset_outputs got %b want 1100000000", {pc_en, if_id_en, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b});
      end
      tick();
    end
    rst = 1'b0; mem_redirect = 1'b0; nop();
    #2;
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got %h/%h want 0000/0000", stall_cnt, flush_cnt);
    end
    checks++;
    if ({pc_en, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL after_reset got %b want 10000000", {pc_en, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b});
    end
    tick();
  endtask

  // Producer then consumer; counts stall cycles the consumer sees.
  task automatic run_pair(string name, bit ld, int exp_stalls, logic [1:0] exp_fa, logic [1:0] exp_fb,
                          logic [4:0] prs, logic [4:0] pdst, logic [4:0] crs, logic [4:0] crt);
    int stalls;
    bit issued;
    stalls = 0; issued = 0;
    do_reset();
    set_id(1, pdst, ld, 1, prs, !ld, 5'd2);
    tick();
    set_id(1, 5'd6, 0, 1, crs, 1, crt);
    for (int i = 0; i < 6 && !issued; i++) begin
      #2;
      if (pc_en !== 1'b1) begin
        stalls++;
        tick();
      end else begin
        issued = 1;
      end
    end
    checks++;
    if (!issued || stalls != exp_stalls) begin
      errors++;
      $display("FAIL %s_stalls got %0d issued %0d want %0d", name, stalls, issued, exp_stalls);
    end
    tick();
    nop();
    #2;
    checks++;
    if (fwd_a !== exp_fa || fwd_b !== exp_fb) begin
      errors++;
      $display("FAIL %s_fwd got %b/%b want %b/%b", name, fwd_a, fwd_b, exp_fa, exp_fb);
    end
    checks++;
    if (stall_cnt !== 16'(exp_stalls)) begin
      errors++;
      $display("FAIL %s_stall_cnt got %0d want %0d", name, stall_cnt, exp_stalls);
    end
    tick();
  endtask

  task automatic test_alu_raw();
    run_pair("alu_raw", 0, FWD ? 0 : 2, FWD ? 2'b01 : 2'b00, 2'b00, 5'd1, 5'd3, 5'd3, 5'd1);
  endtask

  task automatic test_load_use();
    run_pair("load_use", 1, FWD ? 1 : 2, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00, 5'd0, 5'd5, 5'd5, 5'd5);
  endtask

  task automatic test_zero_reg();
    run_pair("zero_reg", 0, 0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_redirect_stall();
    do_reset();
    set_id(1, 5, 1, 1, 0, 0, 0);
    tick();
    set_id(1, 6, 0, 1, 5, 1, 5);
    mem_redirect = 1'b1;
    #2;
    checks++;
    if ({flush_if_id, flush_id_ex, flush_ex_mem, pc_en, if_id_en, id_ex_bubble} !== 6'b111110) begin
      errors++;
      $display("FAIL redirect_outputs got %b want 111110", {flush_if_id, flush_id_ex, flush_ex_mem, pc_en, if_id_en, id_ex_bubble});
    end
    tick();
    mem_redirect = 1'b0;
    #2;
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL redirect_counters got %0d/%0d want 1/0", flush_cnt, stall_cnt);
    end
    checks++;
    if (pc_en !== 1'b1 || flush_if_id !== 1'b0) begin
      errors++;
      $display("FAIL redirect_after got pc_en %b flush %b want 1 0", pc_en, flush_if_id);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1, 5, 1, 1, 0, 0, 0);
    tick();
    set_id(1, 6, 0, 1, 5, 0, 0);
    #2;
    checks++;
    if (id_ex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall_pre got %b want 1", id_ex_bubble);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pc_en !== 1'b1 || id_ex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL mid_stall_rst got %b%b want 10", pc_en, id_ex_bubble);
    end
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if (pc_en !== 1'b1 || id_ex_bubble !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_stall_after got %b%b cnt %0d want 10 cnt 0", pc_en, id_ex_bubble, stall_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0]  obs, exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      mem_redirect = ($urandom_range(0, 99) < 8);
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
      #2;
      model_eval();
      obs = {pc_en, if_id_en, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b};
      exp = {e_pc, e_ifid, e_bub, e_fl, e_fl, e_fl, e_fa, e_fb};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_outputs cycle %0d got %b want %b", i, obs, exp);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== {sat16(m_stalls), sat16(m_flushes)}) begin
        errors++;
        $display("FAIL random_counters cycle %0d got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, sat16(m_stalls), sat16(m_flushes));
      end
      tick();
    end
    rst = 1'b0; mem_redirect = 1'b0;
  endtask

  // Chain of dependent loads keeps the stall counter climbing past 16'hFFFF.
  task automatic test_saturation();
    int  k;
    int  cycles;
    bit  stalled;
    do_reset();
    k = 0; cycles = 0;
    while (m_stalls < 65540 && cycles < 200000) begin
      set_id(1, 5'((k % 7) + 1), 1, 1, 5'(((k + 6) % 7) + 1), 0, 0);
      model_eval();
      stalled = e_stall;
      tick();
      cycles++;
      if (!stalled) k++;
      if (stalled && m_stalls == 65534) begin
        checks++;
        if (stall_cnt !== 16'hFFFE) begin
          errors++;
          $display("FAIL sat_pre got %h want fffe", stall_cnt);
        end
      end
      if (stalled && m_stalls == 65535) begin
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
          errors++;
          $display("FAIL sat_reach got %h want ffff", stall_cnt);
        end
      end
    end
    checks++;
    if (m_stalls < 65540) begin
      errors++;
      $display("FAIL sat_timeout got %0d stalls want 65540", m_stalls);
    end
    nop();
    #2;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold got %h want ffff", stall_cnt);
    end
    tick();
  endtask

  initial begin
    repeat (3) hist.push_back('0);
    rst = 1'b1; mem_redirect = 1'b0; nop();
    @(posedge clk);
    #1;
    test_reset();
    test_alu_raw();
    test_load_use();
    test_zero_reg();
    test_redirect_stall();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
